// File: rtl/fifo_in_mem.sv
// rtl/fifo_in_mem.sv - simple dual-port RAM with registered, resettable read port
module fifo_in_mem #(
    parameter int INW   = 16,
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [INW-1:0] wr_data,
    input  logic           rd_en,
    input  logic [AW-1:0]  rd_addr,
    output logic [INW-1:0] rd_data
);

    logic [INW-1:0] r_mem [DEPTH];
    logic [INW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset so the FIFO output comes up as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_in.sv
// rtl/fifo_in.sv - AXI-Stream slave input FIFO with rd_en/data_out read port
module fifo_in #(
    parameter int INW   = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INW-1:0]               AXIS_TDATA,
    input  logic                         AXIS_TVALID,
    output logic                         AXIS_TREADY,
    input  logic                         rd_en,
    output logic [INW-1:0]               data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    // Ready depends only on registered state, never on rd_en or TVALID.
    assign w_full      = (r_count == CW'(DEPTH));
    assign AXIS_TREADY = !reset && !w_full;
    assign w_wr        = AXIS_TVALID && AXIS_TREADY;
    assign w_rd        = rd_en && (r_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A read needs count>0 and a write needs count<DEPTH, so the ports never collide.
    fifo_in_mem #(
        .INW   (INW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_addr (r_wr_ptr),
        .wr_data (AXIS_TDATA),
        .rd_en   (w_rd),
        .rd_addr (r_rd_ptr),
        .rd_data (data_out)
    );

    assign count = r_count;

endmodule

// File: tb/tb_fifo_in.sv
// tb/tb_fifo_in.sv - self-checking bench for fifo_in at DEPTH=8 and DEPTH=5
module tb_fifo_in;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [15:0] a_tdata;
    logic        a_tvalid;
    logic        a_tready;
    logic        a_rd;
    logic [15:0] a_dout;
    logic [3:0]  a_count;

    logic [15:0] b_tdata;
    logic        b_tvalid;
    logic        b_tready;
    logic        b_rd;
    logic [15:0] b_dout;
    logic [2:0]  b_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_a;
    logic [15:0] exp_b;

    fifo_in #(.INW(16), .DEPTH(8)) u_a (
        .clk(clk), .reset(reset),
        .AXIS_TDATA(a_tdata), .AXIS_TVALID(a_tvalid), .AXIS_TREADY(a_tready),
        .rd_en(a_rd), .data_out(a_dout), .count(a_count)
    );

    fifo_in #(.INW(16), .DEPTH(5)) u_b (
        .clk(clk), .reset(reset),
        .AXIS_TDATA(b_tdata), .AXIS_TVALID(b_tvalid), .AXIS_TREADY(b_tready),
        .rd_en(b_rd), .data_out(b_dout), .count(b_count)
    );

    // Reference: a queue per FIFO; one clock edge of both models, then settle 1ns.
    task automatic step();
        bit wa, ra, wb, rb;
        wa = !reset && a_tvalid && (qa.size() < 8);
        ra = !reset && a_rd && (qa.size() > 0);
        wb = !reset && b_tvalid && (qb.size() < 5);
        rb = !reset && b_rd && (qb.size() > 0);
        @(posedge clk);
        if (ra) exp_a = qa.pop_front();
        if (wa) qa.push_back(a_tdata);
        if (rb) exp_b = qb.pop_front();
        if (wb) qb.push_back(b_tdata);
        #1;
    endtask

    task automatic idle();
        a_tdata = '0; a_tvalid = 1'b0; a_rd = 1'b0;
        b_tdata = '0; b_tvalid = 1'b0; b_rd = 1'b0;
    endtask

    task automatic clear_model();
        qa.delete(); qb.delete();
        exp_a = '0; exp_b = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL reset_tready_a got=%0b exp=0", a_tready); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL reset_count_a got=%0d exp=0", a_count); end
        checks++; if (a_dout !== 16'd0) begin errors++; $display("FAIL reset_dout_a got=%0h exp=0", a_dout); end
        checks++; if (b_count !== 3'd0) begin errors++; $display("FAIL reset_count_b got=%0d exp=0", b_count); end
        reset = 1'b0;
        #1;
        checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL release_tready_a got=%0b exp=1", a_tready); end
        checks++; if (b_tready !== 1'b1) begin errors++; $display("FAIL release_tready_b got=%0b exp=1", b_tready); end
    endtask

    task automatic test_fill();
        int exp_cnt;
        idle();
        for (int i = 1; i <= 12; i++) begin
            a_tdata = 16'(i); a_tvalid = 1'b1;
            step();
            exp_cnt = (i < 8) ? i : 8;
            checks++; if (a_count !== 4'(exp_cnt)) begin errors++; $display("FAIL fill_count word=%0d got=%0d exp=%0d", i, a_count, exp_cnt); end
            checks++; if (a_tready !== (exp_cnt != 8)) begin errors++; $display("FAIL fill_tready word=%0d got=%0b exp=%0b", i, a_tready, exp_cnt != 8); end
        end
        idle();
    endtask

    task automatic test_drain();
        idle();
        for (int i = 1; i <= 8; i++) begin
            a_rd = 1'b1;
            step();
            checks++; if (a_dout !== 16'(i) || a_dout !== exp_a) begin errors++; $display("FAIL drain_dout idx=%0d got=%0d exp=%0d", i, a_dout, i); end
            checks++; if (a_count !== 4'(8 - i)) begin errors++; $display("FAIL drain_count idx=%0d got=%0d exp=%0d", i, a_count, 8 - i); end
        end
        a_rd = 1'b1;
        step();
        checks++; if (a_dout !== 16'd8) begin errors++; $display("FAIL underflow_dout got=%0d exp=8", a_dout); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", a_count); end
        idle();
    endtask

    task automatic test_full_rw();
        idle();
        for (int i = 1; i <= 8; i++) begin
            a_tdata = 16'(100 + i); a_tvalid = 1'b1;
            step();
        end
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL fullrw_prefill got=%0d exp=8", a_count); end
        a_tdata = 16'd200; a_tvalid = 1'b1; a_rd = 1'b1;
        step();
        checks++; if (a_count !== 4'd7) begin errors++; $display("FAIL fullrw_count got=%0d exp=7", a_count); end
        checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL fullrw_tready got=%0b exp=1", a_tready); end
        checks++; if (a_dout !== 16'd101) begin errors++; $display("FAIL fullrw_dout got=%0d exp=101", a_dout); end
        a_tdata = 16'd201; a_rd = 1'b0;
        step();
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL fullrw_refill got=%0d exp=8", a_count); end
        a_tvalid = 1'b0; a_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL fullrw_drain idx=%0d got=%0d exp=%0d", i, a_dout, exp_a); end
        end
        checks++; if (exp_a !== 16'd201) begin errors++; $display("FAIL fullrw_last model=%0d exp=201", exp_a); end
        idle();
    endtask

    task automatic test_wrap();
        idle();
        for (int i = 0; i < 2; i++) begin
            b_tdata = 16'(i); b_tvalid = 1'b1;
            step();
        end
        for (int j = 0; j < 48; j++) begin
            b_tdata = 16'(j + 2); b_tvalid = 1'b1; b_rd = 1'b1;
            step();
            checks++; if (b_dout !== 16'(j)) begin errors++; $display("FAIL wrap_dout idx=%0d got=%0d exp=%0d", j, b_dout, j); end
            checks++; if (b_count !== 3'd2) begin errors++; $display("FAIL wrap_count idx=%0d got=%0d exp=2", j, b_count); end
        end
        b_tvalid = 1'b0;
        for (int j = 48; j < 50; j++) begin
            step();
            checks++; if (b_dout !== 16'(j)) begin errors++; $display("FAIL wrap_tail idx=%0d got=%0d exp=%0d", j, b_dout, j); end
        end
        checks++; if (b_count !== 3'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", b_count); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            a_tdata = 16'h0011 * 16'(i + 1); a_tvalid = 1'b1;
            step();
        end
        a_tvalid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL midrst_tready got=%0b exp=0", a_tready); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", a_count); end
        checks++; if (a_dout !== 16'd0) begin errors++; $display("FAIL midrst_dout got=%0h exp=0", a_dout); end
        a_tdata = 16'hDEAD; a_tvalid = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
        a_tvalid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL midrst_rel_count got=%0d exp=0", a_count); end
        checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL midrst_rel_tready got=%0b exp=1", a_tready); end
        a_tdata = 16'h0044; a_tvalid = 1'b1; step();
        a_tdata = 16'h0055; step();
        a_tvalid = 1'b0; a_rd = 1'b1;
        step();
        checks++; if (a_dout !== 16'h0044) begin errors++; $display("FAIL midrst_rd0 got=%0h exp=44", a_dout); end
        step();
        checks++; if (a_dout !== 16'h0055) begin errors++; $display("FAIL midrst_rd1 got=%0h exp=55", a_dout); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL midrst_end_count got=%0d exp=0", a_count); end
        idle();
    endtask

    task automatic test_soak();
        int nw = 0;
        int nr = 0;
        int cyc = 0;
        bit wa, ra;
        idle();
        while (nw < 10000 && cyc < 60000) begin
            a_tvalid = 1'($urandom % 2);
            a_tdata  = 16'($urandom);
            a_rd     = 1'($urandom % 2) && (qa.size() != 0);
            wa = a_tvalid && (qa.size() < 8);
            ra = a_rd;
            step();
            cyc++;
            if (wa) nw++;
            if (ra) nr++;
            checks++; if (a_count !== 4'(nw - nr) || a_count > 4'd8) begin errors++; $display("FAIL soak_count cyc=%0d got=%0d exp=%0d", cyc, a_count, nw - nr); end
            if (ra) begin
                checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL soak_order cyc=%0d got=%0h exp=%0h", cyc, a_dout, exp_a); end
            end
        end
        checks++; if (nw != 10000) begin errors++; $display("FAIL soak_budget writes=%0d exp=10000", nw); end
        a_tvalid = 1'b0;
        for (int i = 0; i < 8 && qa.size() != 0; i++) begin
            a_rd = 1'b1;
            step();
            checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL soak_drain idx=%0d got=%0h exp=%0h", i, a_dout, exp_a); end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        clear_model();
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_wrap();
        test_reset_mid();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_in.md
Name: fifo_in

Overview:
Input-side FIFO that is the counterpart of fifo_out. Accepts words from an upstream AXI-Stream master (AXIS_TDATA/TVALID/TREADY slave port) and buffers up to DEPTH entries. Presents them to the internal datapath through a simple rd_en/data_out read port with an occupancy count. Sits between the system input stream and the compute core's operand loader.

Parameters:
INW, 16, bits per data word
DEPTH, 16, number of entries; any integer >= 2, not required to be a power of two

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
AXIS_TDATA  input  INW  incoming stream data
AXIS_TVALID  input  1  upstream has valid data
AXIS_TREADY  output  1  FIFO can accept a word this cycle
rd_en  input  1  internal read request; legal only when count != 0
data_out  output  INW  word popped by the most recent accepted rd_en
count  output  $clog2(DEPTH+1)  number of words currently stored

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, data_out=0. AXIS_TREADY=0 while reset is high. Memory contents are don't-care.
- AXIS_TREADY = !reset && (count != DEPTH). It is a function of the registered count only and has no combinational path from rd_en or AXIS_TVALID.
- Write: a transfer occurs on a rising edge with AXIS_TVALID && AXIS_TREADY.
  - mem[wr_ptr] <= AXIS_TDATA
  - wr_ptr advances by 1 and wraps DEPTH-1 -> 0
- Read: an accepted read is rd_en && (count != 0).
  - data_out <= mem[rd_ptr] on that edge, so data_out is valid starting the cycle after rd_en (1-cycle latency).
  - rd_ptr advances and wraps DEPTH-1 -> 0.
  - data_out holds its value until the next accepted read.
- rd_en while count==0 is ignored: no pointer change, data_out unchanged, no underflow.
- count update:
  - +1 on write only
  - -1 on read only
  - unchanged on simultaneous write and read, or on neither
- Full (count==DEPTH): TREADY=0, so no write that cycle even if a read also occurs. TREADY rises the cycle after the read (count is registered).
- Empty (count==0): a write is accepted; the word is readable by rd_en from the next cycle. There is no same-cycle write-through.
- Read and write never address the same entry in one cycle: a read requires count>0 and a write requires count<DEPTH, so no bypass logic is needed.
- Reset asserted mid-transfer: stored data is discarded and outputs return to reset values immediately. A write in progress at that edge is lost.
- Ordering is strict FIFO. No data is duplicated or dropped across any number of pointer wraps.

Decomposition:
- No package needed. Parameters are local, and pointer width is $clog2(DEPTH) with explicit wrap compare (no natural overflow).
- One sub-module, fifo_in_mem: a simple dual-port RAM.
  - Parameters: INW, DEPTH.
  - Ports: clk, wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data.
  - Registered read, 1-cycle latency, no reset on the array.
  - fifo_in drives data_out straight from rd_data.
  - data_out reset is handled by resetting the read-data register inside fifo_in_mem; that one register is the only reset in the sub-module.

Test Plan:
- Fill: DEPTH=8, TVALID held high with TDATA=1..8 and rd_en=0.
  - Required: 8 transfers, count steps 1..8, TREADY=0 from the cycle count=8.
  - Words 9..12 are not accepted.
- Drain: from full, rd_en=1 for 8 cycles.
  - Required: data_out=1..8, each one cycle after its rd_en, count ends at 0.
  - An extra rd_en at count=0 leaves data_out=8 and count=0.
- Full plus simultaneous read: at count=8 drive TVALID=1 and rd_en=1 in the same cycle.
  - Required: no write that cycle; count=7 next cycle with TREADY=1.
  - The following write brings count back to 8.
- Wrap and steady stream: DEPTH=5 (non-power-of-two), TVALID=1 and rd_en=1 every cycle after 2 preloads, 50 words.
  - Required: count stays at 2 and the output sequence is exactly 0..49 across 10 pointer wraps.
- Reset mid-operation: load 3 words, assert reset asynchronously between edges.
  - Required: TREADY=0 and count=0 immediately.
  - After release: count=0, TREADY=1, and the next words read are only those written after reset.
- Random soak: 10000 words with TVALID probability 0.5 and rd_en probability 0.5 (gated by count!=0).
  - Required: zero ordering errors.
  - count must always equal writes minus reads and stay within 0..DEPTH.
